// File: rtl/addr8s_sched_pkg.sv
// Shared types and widths for the dual-pass adder scheduler.
package addr8s_sched_pkg;
  localparam int OPW  = 8;
  localparam int SUMW = 9;
  localparam int FCW  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/addr8s_dmr_sched_rr_arbiter.sv
// Round-robin arbiter: searches from (last+1) mod NREQ and returns a one-hot
// grant plus its encoded index. No grant when enable is low.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  int   pos;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    pos   = 0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = (int'(last) + k) % NREQ;
      if (enable && !found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDW'(pos);
      end
    end
  end
endmodule

// File: rtl/addr8s_dmr_sched.sv
// Shares one external combinational adder among NREQ clients; every operation
// runs twice (operands swapped on the second pass) and mismatches are retried.
module addr8s_dmr_sched
  import addr8s_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 2,
  parameter int IDW       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [OPW*NREQ-1:0]  req_a,
  input  logic [OPW*NREQ-1:0]  req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [OPW-1:0]       adder_a,
  output logic [OPW-1:0]       adder_b,
  input  logic [SUMW-1:0]      adder_o,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [SUMW-1:0]      rsp_sum,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [FCW-1:0]       fault_cnt,
  output logic [1:0]           fsm_state
);
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_t          state, state_n;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  gidx;
  logic [NREQ-1:0] grant;
  logic [OPW-1:0]  a_q, b_q, sel_a, sel_b;
  logic [IDW-1:0]  id_q;
  logic [SUMW-1:0] sum1;
  logic [RW-1:0]   retry_cnt;
  logic            match;
  logic            can_retry;

  // Handshakes: a request transfers on req_valid[i] && req_ready[i]; a
  // response transfers on rsp_valid && rsp_ready. req_ready is only offered
  // in IDLE outside reset; rsp_valid is held with stable payload in RESP.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .enable (state == IDLE && rst_n),
    .last   (last_grant),
    .grant  (grant),
    .idx    (gidx)
  );

  assign req_ready = grant;
  assign busy      = (state != IDLE);
  assign fsm_state = state;
  assign sel_a     = req_a[int'(gidx)*OPW +: OPW];
  assign sel_b     = req_b[int'(gidx)*OPW +: OPW];
  assign match     = (adder_o == sum1);
  assign can_retry = (retry_cnt < RW'(MAX_RETRY));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|grant) state_n = RUN_A;
      RUN_A:   state_n = RUN_B;
      RUN_B:   state_n = (!match && can_retry) ? RUN_A : RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      sum1       <= '0;
      retry_cnt  <= '0;
      adder_a    <= '0;
      adder_b    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_err    <= 1'b0;
      fault_cnt  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (|grant) begin
            a_q        <= sel_a;
            b_q        <= sel_b;
            id_q       <= gidx;
            last_grant <= gidx;
            retry_cnt  <= '0;
            adder_a    <= sel_a;
            adder_b    <= sel_b;
          end
        end
        RUN_A: begin
          sum1    <= adder_o;
          adder_a <= b_q;
          adder_b <= a_q;
        end
        RUN_B: begin
          if (!match && fault_cnt != '1) fault_cnt <= fault_cnt + 8'd1;
          if (!match && can_retry) begin
            retry_cnt <= retry_cnt + RW'(1);
            adder_a   <= a_q;
            adder_b   <= b_q;
          end else begin
            // Final compare: the reported sum is always the last pass-A result.
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_sum   <= sum1;
            rsp_err   <= !match;
            adder_a   <= '0;
            adder_b   <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_addr8s_dmr_sched.sv
// Scoreboarded bench: drivers issue requests, a reference model predicts grant
// order, sums, retries and latency, and a monitor checks every response.
module tb_addr8s_dmr_sched;
  localparam int NREQ      = 4;
  localparam int MAX_RETRY = 2;
  localparam int IDW       = 3;
  localparam int EW        = IDW + 9 + 1 + 8;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [8*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0] req_ready;
  logic [7:0]      adder_a, adder_b;
  logic [8:0]      adder_o;
  logic            rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [8:0]      rsp_sum;
  logic            rsp_err, busy;
  logic [7:0]      fault_cnt;
  logic [1:0]      fsm_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // scoreboard: {id, sum, err, latency}
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            m_last;
  int            m_fcnt;
  logic          prev_valid;

  int         fault_mode;   // 0 clean, 1 flip bit0 on first swapped pass, 2 bit3 stuck-1 on swapped pass
  logic [7:0] cur_a, cur_b;
  logic       flip_done;
  logic       pass_b;
  logic       rdy_rand;

  addr8s_dmr_sched #(.NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .adder_a(adder_a), .adder_b(adder_b), .adder_o(adder_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_err(rsp_err), .busy(busy), .fault_cnt(fault_cnt), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external adder with injectable faults on the swapped pass
  assign pass_b = (cur_a != cur_b) && (adder_a == cur_b) && (adder_b == cur_a);
  always_comb begin
    adder_o = {adder_a[7], adder_a} + {adder_b[7], adder_b};
    if (pass_b && fault_mode == 1 && !flip_done) adder_o[0] = ~adder_o[0];
    else if (pass_b && fault_mode == 2) adder_o[3] = 1'b1;
  end
  always @(posedge clk) begin
    if (!rst_n) flip_done <= 1'b0;
    else if (|(req_valid & req_ready)) flip_done <= 1'b0;
    else if (pass_b && fault_mode == 1) flip_done <= 1'b1;
  end

  initial begin
    rdy_rand = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor + reference model
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      m_last     = NREQ - 1;
      m_fcnt     = 0;
      prev_valid = 1'b0;
    end else begin
      if (|(req_valid & req_ready)) begin
        int j;
        int mism;
        logic [NREQ-1:0] eg;
        logic [7:0] a, b;
        logic [8:0] s;
        j = -1;
        for (int k = 1; k <= NREQ; k++)
          if (j < 0 && req_valid[(m_last + k) % NREQ]) j = (m_last + k) % NREQ;
        eg = '0;
        eg[j] = 1'b1;
        check("grant", 32'(req_ready), 32'(eg));
        a = req_a[j*8 +: 8];
        b = req_b[j*8 +: 8];
        cur_a = a;
        cur_b = b;
        s = 9'($signed(a) + $signed(b));
        mism = (fault_mode == 0) ? 0 : (fault_mode == 1) ? 1 : MAX_RETRY + 1;
        m_fcnt = (m_fcnt + mism > 255) ? 255 : m_fcnt + mism;
        exp_q.push_back({IDW'(j), s, 1'(fault_mode == 2),
                         8'(3 + 2 * ((mism < MAX_RETRY) ? mism : MAX_RETRY))});
        acc_q.push_back(cyc);
        m_last = j;
      end
      if (rsp_valid && !prev_valid) begin
        if (acc_q.size() > 0) check("latency", 32'(cyc - acc_q[0]), 32'(exp_q[0][7:0]));
        else check("spurious_rsp", 32'(1), 32'(0));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() > 0) begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          void'(acc_q.pop_front());
          check("rsp_id", 32'(rsp_id), 32'(e[EW-1 -: IDW]));
          check("rsp_sum", 32'(rsp_sum), 32'(e[17:9]));
          check("rsp_err", 32'(rsp_err), 32'(e[8]));
          check("fault_cnt", 32'(fault_cnt), 32'(m_fcnt));
        end else check("unexpected_rsp", 32'(1), 32'(0));
      end
      prev_valid = rsp_valid;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) ok = 1'b1;
    end
    if (!ok) check("accept_timeout", 32'(1), 32'(0));
    step();
  endtask

  task automatic wait_resp();
    bit ok = 1'b0;
    for (int t = 0; t < 80 && !ok; t++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) ok = 1'b1;
    end
    if (!ok) check("resp_timeout", 32'(1), 32'(0));
    step();
  endtask

  task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b, input int mode);
    fault_mode = mode;
    set_op(i, a, b);
    req_valid = '0;
    req_valid[i] = 1'b1;
    wait_accept();
    req_valid = '0;
    wait_resp();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'(0));
    check({tag, "_rsp_sum"}, 32'(rsp_sum), 32'(0));
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_fault_cnt"}, 32'(fault_cnt), 32'(0));
    check({tag, "_adder"}, 32'({adder_a, adder_b}), 32'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    fault_mode = 0;
    cur_a = '0;
    cur_b = '0;
    repeat (3) step();
    @(negedge clk);
    check_idle_outputs("reset");
    step();
    rst_n = 1'b1;
    step();

    // directed arithmetic cases
    run_op(1, 8'h7F, 8'h01, 0);
    run_op(0, 8'h80, 8'h80, 0);
    run_op(0, 8'hFF, 8'h01, 0);

    // all requesters active: strict rotation
    for (int i = 0; i < NREQ; i++) set_op(i, 8'($urandom), 8'($urandom));
    req_valid = '1;
    for (int n = 0; n < 16; n++) begin
      int g;
      g = -1;
      @(negedge clk);
      for (int t = 0; t < 20 && !(|(req_valid & req_ready)); t++) @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
      if (g < 0) check("rotation_timeout", 32'(1), 32'(0));
      step();
      if (g >= 0) set_op(g, 8'($urandom), 8'($urandom));
    end
    req_valid = '0;
    wait_resp();

    // transient fault: one retry; persistent fault: retries exhausted
    run_op(2, 8'd5, 8'd3, 1);
    run_op(3, 8'd1, 8'd2, 2);

    // randomized traffic with random response back-pressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [NREQ-1:0] m;
      for (int i = 0; i < NREQ; i++) set_op(i, 8'($urandom), 8'($urandom));
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      fault_mode = $urandom_range(0, 1);
      for (int i = 0; i < NREQ; i++)
        if (m[i] && req_a[i*8 +: 8] == req_b[i*8 +: 8]) fault_mode = 0;
      req_valid = m;
      wait_accept();
      req_valid = '0;
      wait_resp();
    end
    rdy_rand = 1'b0;
    fault_mode = 0;

    // stalled response, then reset in the middle of the next operation
    rsp_ready = 1'b0;
    set_op(2, 8'h10, 8'hF0);
    req_valid = 4'b0100;
    wait_accept();
    req_valid = '0;
    for (int t = 0; t < 20 && !rsp_valid; t++) @(negedge clk);
    repeat (10) step();
    rsp_ready = 1'b1;
    wait_resp();
    set_op(3, 8'h22, 8'h33);
    req_valid = 4'b1000;
    wait_accept();
    step();
    rst_n = 1'b0;
    req_valid = '1;
    step();
    @(negedge clk);
    check_idle_outputs("midop_reset");
    step();
    rst_n = 1'b1;
    wait_accept();
    req_valid = '0;
    wait_resp();

    repeat (4) step();
    check("drain", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
